// File: rtl/uart_pkt_defs.sv
// Shared constants for the UART packet parser: header bytes, error causes,
// parser state encodings and the buffer address-width helper.
package uart_pkt_defs;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_H0  = 3'd0,
    ST_H1  = 3'd1,
    ST_LEN = 3'd2,
    ST_PAY = 3'd3,
    ST_CHK = 3'd4
  } pkt_state_e;

  // A one-entry buffer still needs a one-bit address port.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Payload buffer: single write port, registered read port (1-cycle latency).
// Only the read register is reset; the array itself maps onto block RAM.
module pkt_buf_ram #(
  parameter int unsigned AW = 6
) (
  input  logic          clk_100M,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk_100M) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser behind the UART byte receiver: 55 AA LEN payload CHK.
// A validated payload is held in pkt_buf_ram until the host acknowledges it.
module uart_pkt_parser
  import uart_pkt_defs::*;
#(
  parameter int unsigned MAX_LEN        = 64,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000
) (
  input  logic                       clk_100M,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_irq,
  output logic                       pkt_valid,
  output logic [7:0]                 pkt_len,
  input  logic                       pkt_ack,
  input  logic [addr_w(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned AW        = addr_w(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  pkt_state_e  state_reg;
  logic        rx_irq_d;
  logic [7:0]  len_reg;
  logic [7:0]  sum_reg;
  logic [7:0]  idx_reg;
  logic [31:0] tmo_cnt_reg;
  logic        stb;
  logic        held;
  logic        timeout;
  logic        wr_en;

  assign stb     = rx_irq & ~rx_irq_d;
  // An ack in this cycle frees the buffer for a header arriving in the same cycle.
  assign held    = pkt_valid & ~pkt_ack;
  assign timeout = (state_reg != ST_H0) && !stb && (tmo_cnt_reg == TIMEOUT_CYCLES - 32'd1);
  assign wr_en   = stb && (state_reg == ST_PAY);

  pkt_buf_ram #(
    .AW(AW)
  ) u_buf (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .we       (wr_en),
    .waddr    (idx_reg[AW-1:0]),
    .wdata    (rx_byte),
    .raddr    (rd_addr),
    .rdata    (rd_data)
  );

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_H0;
      rx_irq_d    <= 1'b0;
      len_reg     <= '0;
      sum_reg     <= '0;
      idx_reg     <= '0;
      tmo_cnt_reg <= '0;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      err         <= 1'b0;
      err_code    <= '0;
      drop_cnt    <= '0;
    end else begin
      rx_irq_d <= rx_irq;
      err      <= 1'b0;
      if (pkt_valid && pkt_ack)
        pkt_valid <= 1'b0;
      if (stb || state_reg == ST_H0)
        tmo_cnt_reg <= '0;
      else
        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;

      // A strobe in the same cycle suppresses the timeout, so at most one error fires.
      if (timeout) begin
        state_reg <= ST_H0;
        err       <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else if (stb) begin
        case (state_reg)
          ST_H0: begin
            if (held) begin
              if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
              if (rx_byte == HDR0) begin
                err      <= 1'b1;
                err_code <= ERR_OVERRUN;
              end
            end else if (rx_byte == HDR0) begin
              state_reg <= ST_H1;
            end
          end
          ST_H1: begin
            if (rx_byte == HDR1)
              state_reg <= ST_LEN;
            else if (rx_byte != HDR0)
              state_reg <= ST_H0;
          end
          ST_LEN: begin
            if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
              state_reg <= ST_H0;
              err       <= 1'b1;
              err_code  <= ERR_LEN;
            end else begin
              len_reg   <= rx_byte;
              sum_reg   <= rx_byte;
              idx_reg   <= '0;
              state_reg <= ST_PAY;
            end
          end
          ST_PAY: begin
            sum_reg <= sum_reg + rx_byte;
            idx_reg <= idx_reg + 8'd1;
            if (idx_reg == len_reg - 8'd1)
              state_reg <= ST_CHK;
          end
          ST_CHK: begin
            state_reg <= ST_H0;
            if (rx_byte == sum_reg) begin
              pkt_valid <= 1'b1;
              pkt_len   <= len_reg;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_CHK;
            end
          end
          default: state_reg <= ST_H0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Bench for uart_pkt_parser: directed frame table, hand-written corner sequences
// and randomized frames predicted from frame-level rules (header, length, checksum).
`timescale 1ns/1ps
module tb_uart_pkt_parser;

  localparam int MAX_LEN = 64;
  localparam int AW      = 6;

  logic          clk_100M = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_byte;
  logic          rx_irq;
  logic          pkt_valid;
  logic [7:0]    pkt_len;
  logic          pkt_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err;
  logic [1:0]    err_code;
  logic [15:0]   drop_cnt;

  int         checks   = 0;
  int         errors   = 0;
  int         err_seen = 0;
  logic [1:0] last_code = 2'd0;
  int         exp_drop = 0;
  logic [7:0] cur_pay[$];
  logic [7:0] cur_chk;

  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] bytes;     // byte k at [63-8k -: 8]
    logic        exp_valid;
    logic [7:0]  exp_len;
    logic [23:0] exp_pay;   // payload byte k at [23-8k -: 8]
    logic [1:0]  exp_errs;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs [8];

  always #5 clk_100M = ~clk_100M;

  uart_pkt_parser #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (32'd10_000)
  ) dut (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_irq    (rx_irq),
    .pkt_valid (pkt_valid),
    .pkt_len   (pkt_len),
    .pkt_ack   (pkt_ack),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .err       (err),
    .err_code  (err_code),
    .drop_cnt  (drop_cnt)
  );

  always @(posedge clk_100M) begin
    #1;
    if (err) begin
      err_seen++;
      last_code = err_code;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk_100M);
    rx_byte = b;
    rx_irq  = 1'b1;
    repeat (hold) @(negedge clk_100M);
    rx_irq = 1'b0;
    repeat (gap) @(negedge clk_100M);
  endtask

  task automatic send_rand(input logic [7:0] b);
    send_byte(b, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
  endtask

  function automatic logic [7:0] junk();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h55)
      b = 8'h54;
    return b;
  endfunction

  task automatic build_good(input int len);
    logic [7:0] s;
    logic [7:0] b;
    cur_pay.delete();
    s = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      cur_pay.push_back(b);
      s = s + b;
    end
    cur_chk = s;
  endtask

  task automatic send_frame();
    send_rand(8'h55);
    send_rand(8'hAA);
    send_rand(8'(cur_pay.size()));
    foreach (cur_pay[i])
      send_rand(cur_pay[i]);
    send_rand(cur_chk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_100M);
  endtask

  task automatic read_check(input string tag);
    foreach (cur_pay[i]) begin
      rd_addr = AW'(i);
      @(negedge clk_100M);
      check($sformatf("%s rd_data[%0d]", tag, i), 32'(rd_data), 32'(cur_pay[i]));
    end
  endtask

  task automatic do_ack(input string tag);
    pkt_ack = 1'b1;
    @(negedge clk_100M);
    pkt_ack = 1'b0;
    check({tag, " valid after ack"}, 32'(pkt_valid), 32'd0);
  endtask

  initial begin
    int base;
    int kind;
    int nj;
    int nb;
    int n55;
    int first;
    int n;
    int len;
    logic [7:0] b;
    logic [7:0] blen;
    logic [1:0] code;

    vecs[0] = '{4'd6, 64'h55AA_0210_2031_0000, 1'b0, 8'd0, 24'h000000, 2'd1, 2'd1};
    vecs[1] = '{4'd7, 64'h55AA_0301_0203_0900, 1'b1, 8'd3, 24'h010203, 2'd0, 2'd0};
    vecs[2] = '{4'd3, 64'h55AA_0000_0000_0000, 1'b0, 8'd0, 24'h000000, 2'd1, 2'd0};
    vecs[3] = '{4'd3, 64'h55AA_4100_0000_0000, 1'b0, 8'd0, 24'h000000, 2'd1, 2'd0};
    vecs[4] = '{4'd6, 64'h5555_AA01_5A5B_0000, 1'b1, 8'd1, 24'h5A0000, 2'd0, 2'd0};
    vecs[5] = '{4'd6, 64'h55AA_0255_AA01_0000, 1'b1, 8'd2, 24'h55AA00, 2'd0, 2'd0};
    vecs[6] = '{4'd7, 64'h13AA_55AA_0100_0100, 1'b1, 8'd1, 24'h000000, 2'd0, 2'd0};
    vecs[7] = '{4'd5, 64'h55AA_01C3_0000_0000, 1'b0, 8'd0, 24'h000000, 2'd1, 2'd1};

    rst_n   = 1'b0;
    rx_byte = 8'd0;
    rx_irq  = 1'b0;
    pkt_ack = 1'b0;
    rd_addr = '0;
    repeat (3) @(negedge clk_100M);
    check("reset pkt_valid", 32'(pkt_valid), 32'd0);
    check("reset pkt_len", 32'(pkt_len), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100M);

    // Good frame with exact one-edge latency on the CHK byte.
    cur_pay = '{8'h01, 8'h02, 8'h03};
    base = err_seen;
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h03, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h03, 1, 1);
    @(negedge clk_100M);
    check("valid before chk", 32'(pkt_valid), 32'd0);
    rx_byte = 8'h09;
    rx_irq  = 1'b1;
    @(negedge clk_100M);
    check("valid one edge after chk", 32'(pkt_valid), 32'd1);
    rx_irq = 1'b0;
    check("good pkt_len", 32'(pkt_len), 32'd3);
    read_check("good");
    check("good err count", 32'(err_seen - base), 32'd0);
    do_ack("good");
    $display("seq good: 55 AA 03 01 02 03 09");

    for (int v = 0; v < 8; v++) begin
      base = err_seen;
      for (int k = 0; k < int'(vecs[v].n); k++)
        send_byte(vecs[v].bytes[63-8*k -: 8], 1, 1);
      settle();
      $display("vector %0d: %0d bytes", v, vecs[v].n);
      check($sformatf("vec%0d valid", v), 32'(pkt_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d err count", v), 32'(err_seen - base), 32'(vecs[v].exp_errs));
      if (vecs[v].exp_errs != 2'd0)
        check($sformatf("vec%0d err_code", v), 32'(last_code), 32'(vecs[v].exp_code));
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d pkt_len", v), 32'(pkt_len), 32'(vecs[v].exp_len));
        for (int k = 0; k < int'(vecs[v].exp_len); k++) begin
          rd_addr = AW'(k);
          @(negedge clk_100M);
          check($sformatf("vec%0d rd_data[%0d]", v, k), 32'(rd_data), 32'(vecs[v].exp_pay[23-8*k -: 8]));
        end
        do_ack($sformatf("vec%0d", v));
      end
    end

    // rx_irq held high for 50 cycles must count as a single payload byte.
    base = err_seen;
    cur_pay = '{8'h10, 8'h20};
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h10, 50, 1);
    send_byte(8'h20, 1, 1);
    send_byte(8'h32, 1, 1);
    settle();
    $display("seq long strobe: 55 AA 02 10(x50) 20 32");
    check("long strobe valid", 32'(pkt_valid), 32'd1);
    check("long strobe len", 32'(pkt_len), 32'd2);
    check("long strobe err count", 32'(err_seen - base), 32'd0);
    read_check("long strobe");
    do_ack("long strobe");

    // Overrun: frame held without ack, second frame dropped byte by byte.
    cur_pay = '{8'h42};
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h42, 1, 1);
    send_byte(8'h43, 1, 1);
    settle();
    check("overrun first valid", 32'(pkt_valid), 32'd1);
    base = err_seen;
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h7E, 1, 1);
    send_byte(8'h7F, 1, 1);
    settle();
    exp_drop += 5;
    $display("seq overrun: 55 AA 01 7E 7F while held");
    check("overrun err count", 32'(err_seen - base), 32'd1);
    check("overrun err_code", 32'(last_code), 32'd3);
    check("overrun drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("overrun still valid", 32'(pkt_valid), 32'd1);
    read_check("overrun buffer");

    // Ack and a 0x55 strobe in the same cycle: header accepted, no overrun.
    base = err_seen;
    pkt_ack = 1'b1;
    rx_byte = 8'h55;
    rx_irq  = 1'b1;
    @(negedge clk_100M);
    pkt_ack = 1'b0;
    rx_irq  = 1'b0;
    check("ack+hdr valid cleared", 32'(pkt_valid), 32'd0);
    cur_pay = '{8'h66};
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h66, 1, 1);
    send_byte(8'h67, 1, 1);
    settle();
    $display("seq ack with header: ack+55 AA 01 66 67");
    check("ack+hdr valid", 32'(pkt_valid), 32'd1);
    check("ack+hdr err count", 32'(err_seen - base), 32'd0);
    check("ack+hdr drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    read_check("ack+hdr");
    do_ack("ack+hdr");

    // Timeout mid-payload.
    base = err_seen;
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h04, 1, 1);
    send_byte(8'h11, 1, 1);
    first = -1;
    n = 0;
    code = 2'd0;
    for (int c = 0; c < 10200; c++) begin
      @(negedge clk_100M);
      if (err) begin
        n++;
        code = err_code;
        if (first < 0)
          first = c;
      end
    end
    $display("seq timeout: 55 AA 04 11 then idle, err after %0d cycles", first);
    check("timeout err count", 32'(n), 32'd1);
    check("timeout err_code", 32'(code), 32'd2);
    check("timeout latency in window", 32'(first >= 9985 && first <= 10010), 32'd1);
    build_good(5);
    send_frame();
    settle();
    check("post-timeout valid", 32'(pkt_valid), 32'd1);
    check("post-timeout len", 32'(pkt_len), 32'd5);
    read_check("post-timeout");
    do_ack("post-timeout");

    // Reset pulsed mid-payload clears every output and drops the partial frame.
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h04, 1, 1);
    send_byte(8'h11, 1, 1);
    send_byte(8'h22, 1, 1);
    rd_addr = '0;
    @(negedge clk_100M);
    @(negedge clk_100M);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset pkt_valid", 32'(pkt_valid), 32'd0);
    check("mid reset pkt_len", 32'(pkt_len), 32'd0);
    check("mid reset rd_data", 32'(rd_data), 32'd0);
    check("mid reset err_code", 32'(err_code), 32'd0);
    check("mid reset drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk_100M);
    rst_n = 1'b1;
    exp_drop = 0;
    base = err_seen;
    send_byte(8'h33, 1, 1);
    send_byte(8'h44, 1, 1);
    send_byte(8'hAE, 1, 1);
    settle();
    $display("seq reset mid-payload, tail 33 44 AE sent after reset");
    check("after reset tail valid", 32'(pkt_valid), 32'd0);
    check("after reset tail err count", 32'(err_seen - base), 32'd0);

    for (int f = 0; f < 20; f++) begin
      kind = int'($urandom_range(0, 4));
      base = err_seen;
      case (kind)
        0, 1: begin
          nj = int'($urandom_range(0, 3));
          repeat (nj) send_rand(junk());
          len = ($urandom_range(0, 3) == 0) ? MAX_LEN : int'($urandom_range(1, MAX_LEN));
          build_good(len);
          send_frame();
          settle();
          check($sformatf("rnd%0d good valid", f), 32'(pkt_valid), 32'd1);
          check($sformatf("rnd%0d good len", f), 32'(pkt_len), 32'(len));
          check($sformatf("rnd%0d good err count", f), 32'(err_seen - base), 32'd0);
          read_check($sformatf("rnd%0d", f));
          do_ack($sformatf("rnd%0d", f));
        end
        2: begin
          build_good(int'($urandom_range(1, 16)));
          cur_chk = cur_chk ^ 8'($urandom_range(1, 255));
          send_frame();
          settle();
          check($sformatf("rnd%0d badchk valid", f), 32'(pkt_valid), 32'd0);
          check($sformatf("rnd%0d badchk err count", f), 32'(err_seen - base), 32'd1);
          check($sformatf("rnd%0d badchk err_code", f), 32'(last_code), 32'd1);
        end
        3: begin
          blen = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
          send_rand(8'h55);
          send_rand(8'hAA);
          send_rand(blen);
          settle();
          check($sformatf("rnd%0d badlen valid", f), 32'(pkt_valid), 32'd0);
          check($sformatf("rnd%0d badlen err count", f), 32'(err_seen - base), 32'd1);
          check($sformatf("rnd%0d badlen err_code", f), 32'(last_code), 32'd0);
        end
        default: begin
          build_good(int'($urandom_range(1, 8)));
          send_frame();
          settle();
          check($sformatf("rnd%0d held valid", f), 32'(pkt_valid), 32'd1);
          base = err_seen;
          n55 = 0;
          nb = int'($urandom_range(1, 8));
          for (int j = 0; j < nb; j++) begin
            b = ($urandom_range(0, 1) == 0) ? 8'h55 : junk();
            if (b == 8'h55)
              n55++;
            send_rand(b);
          end
          exp_drop += nb;
          settle();
          check($sformatf("rnd%0d overrun err count", f), 32'(err_seen - base), 32'(n55));
          if (n55 > 0)
            check($sformatf("rnd%0d overrun err_code", f), 32'(last_code), 32'd3);
          check($sformatf("rnd%0d overrun still valid", f), 32'(pkt_valid), 32'd1);
          read_check($sformatf("rnd%0d held buffer", f));
          do_ack($sformatf("rnd%0d", f));
        end
      endcase
      check($sformatf("rnd%0d drop_cnt", f), 32'(drop_cnt), 32'(exp_drop));
      $display("random frame %0d: kind %0d, payload %0d bytes", f, kind, cur_pay.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
- Downstream consumer of the UART byte receiver.
- Takes the received byte plus its completion flag (rising edge = new byte) and assembles framed packets.
- Frame format: 0x55, 0xAA, LEN, LEN payload bytes, CHK.
- Validated payloads are held in an internal buffer for a host-side reader, with a level-valid/ack handshake and error reporting.

Parameters:
- MAX_LEN, 64, maximum payload bytes accepted (1..255); buffer depth.
- TIMEOUT_CYCLES, 32'd10_000, idle clk_100M cycles between bytes inside a frame before abort.

Ports:
- clk_100M  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_byte  in  8  received byte; stable while rx_irq is high.
- rx_irq  in  1  byte-complete flag, synchronous to clk_100M; rising edge = new byte.
- pkt_valid  out  1  level; a validated packet is held in the buffer.
- pkt_len  out  8  payload length of the held packet.
- pkt_ack  in  1  one-cycle pulse; releases the buffer.
- rd_addr  in  $clog2(MAX_LEN)  payload read index.
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle read latency.
- err  out  1  one-cycle pulse on any frame error.
- err_code  out  2  cause, valid with err: 0 = LEN, 1 = CHK, 2 = TIMEOUT, 3 = OVERRUN.
- drop_cnt  out  16  bytes discarded while pkt_valid is held; saturates at 0xFFFF.

Behaviour:
- Reset (rst_n low, async) clears all outputs to 0: pkt_valid, pkt_len, rd_data, err, err_code, drop_cnt. FSM goes to H0. Buffer contents are don't-care.
- Byte strobe:
  - rx_irq_d register; stb = rx_irq & ~rx_irq_d.
  - One stb per rising edge, regardless of how long rx_irq stays high.
  - rx_byte is sampled in the stb cycle.
- FSM states: H0, H1, LEN, PAY, CHK. Transitions occur only on stb, except the timeout.
  - H0: 0x55 and not pkt_valid -> H1. 0x55 while pkt_valid -> stay, err OVERRUN, drop_cnt+1. Any other byte while pkt_valid -> drop_cnt+1 only. Otherwise stay.
  - H1: 0xAA -> LEN. 0x55 -> stay in H1. Otherwise -> H0.
  - LEN: byte 0 or byte > MAX_LEN -> H0, err LEN. Otherwise latch len, sum = byte, idx = 0 -> PAY.
  - PAY: buffer[idx] = byte, sum += byte (mod 256), idx+1. When idx == len-1 -> CHK.
  - CHK: byte == sum -> pkt_valid = 1, pkt_len = len, -> H0. Mismatch -> err CHK, -> H0, pkt_valid stays 0.
- Latency: pkt_valid is high after the first clk_100M edge at which the CHK byte's rx_irq is sampled 1.
- Timeout: counter clears on every stb. In any state other than H0, the count reaching TIMEOUT_CYCLES -> H0, err TIMEOUT (single pulse).
- Handshake: pkt_ack while pkt_valid -> pkt_valid = 0 on the next edge. pkt_ack while pkt_valid is 0 is ignored.
  - Header is accepted only while pkt_valid is 0, so the buffer is never written while held.
  - pkt_ack and a stb of 0x55 in the same cycle: ack wins first, and the 0x55 is accepted (FSM -> H1, no OVERRUN).
- err priority: at most one error per cycle. A timeout and an stb in the same cycle: the stb is processed and the timeout is not raised.
- rd_addr >= pkt_len returns stale buffer contents; not an error.
- Reset mid-frame: partial frame discarded; FSM at H0.

Decomposition:
- Shared include/package uart_pkt_defs holds:
  - header constants HDR0 = 8'h55, HDR1 = 8'hAA;
  - err_code values;
  - FSM state encodings.
- One sub-module: pkt_buf_ram, a single-port-write / registered-read 8 x MAX_LEN array.
- FSM, strobe detection, timeout counter and checksum stay in the top level.

Test Plan:
- Good frame: send 55 AA 03 01 02 03 09 -> pkt_valid = 1, pkt_len = 3. Reading addr 0..2 gives 01 02 03, each 1 cycle after addr. No err.
- Bad checksum: 55 AA 02 10 20 31 -> err pulse, code 1. pkt_valid stays 0. Follow with a good frame -> accepted.
- Length errors:
  - 55 AA 00 -> err code 0.
  - With MAX_LEN = 64, 55 AA 41 -> err code 0.
  - Both return to H0.
- Timeout: 55 AA 04 11, then idle 10_000 cycles -> single err code 2. A later good frame is parsed correctly.
- Overrun: first frame valid, no ack; send 55 AA 01 7E 7F -> err code 3 once (on the 55), drop_cnt = 5. Buffer unchanged. After pkt_ack, pkt_valid = 0 and a new frame is accepted.
- Resync and strobes:
  - 55 55 AA 01 5A 5B -> valid packet with payload 5A.
  - rx_irq held high 50 cycles yields exactly one byte.
  - rst_n pulsed mid-payload clears all outputs.
